// File: rtl/ifu_icache.sv
// Direct-mapped, blocking instruction cache. The slave side serves IFU AXI-lite
// reads with the aligned 64-bit doubleword. A miss fetches one doubleword over
// the AXI-lite master port. At most one miss is outstanding, so responses stay
// in request order.
module ifu_icache #(
  parameter int ENTRY_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fence_i,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [63:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [1:0]  ifu_rresp,
  output logic [63:0] ifu_rdata,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [63:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [1:0]  mem_rresp,
  input  logic [63:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IDX  = $clog2(ENTRY_NUM);
  localparam int TAGW = 61 - IDX;

  typedef enum logic [1:0] {IDLE, MISS_AR, MISS_R} state_t;

  state_t               state;
  logic [ENTRY_NUM-1:0] valid;
  logic [TAGW-1:0]      tag_q  [ENTRY_NUM];
  logic [63:0]          data_q [ENTRY_NUM];
  logic [60:0]          miss_line;   // doubleword address of the outstanding miss
  logic                 squash;      // fence seen while a miss was in flight

  logic [IDX-1:0]  req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            hit, accept, fill, fill_we;
  logic            unused_ok;

  // Byte offset within the doubleword plays no part in lookup.
  assign unused_ok = &{1'b0, ifu_araddr[2:0]};

  assign req_idx  = ifu_araddr[IDX+2:3];
  assign req_tag  = ifu_araddr[63:IDX+3];
  assign fill_idx = miss_line[IDX-1:0];
  assign fill_tag = miss_line[60:IDX];

  assign hit         = valid[req_idx] && (tag_q[req_idx] == req_tag);
  assign ifu_arready = (state == IDLE) && (!ifu_rvalid || ifu_rready);
  assign accept      = ifu_arvalid && ifu_arready;
  assign mem_rready  = (state == MISS_R) && (!ifu_rvalid || ifu_rready);
  assign fill        = mem_rvalid && mem_rready;
  // A fence in the fill cycle wins over allocation.
  assign fill_we     = fill && (mem_rresp == 2'b00) && !squash && !fence_i;
  assign mem_araddr  = {miss_line, 3'b000};

  // Line storage: tag and data carry no reset, valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

  // Control FSM, response register, valid bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      miss_line   <= '0;
      squash      <= 1'b0;
      mem_arvalid <= 1'b0;
      ifu_rvalid  <= 1'b0;
      ifu_rresp   <= 2'b00;
      ifu_rdata   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      if (fence_i)      valid           <= '0;
      else if (fill_we) valid[fill_idx] <= 1'b1;

      if (accept && hit) begin
        ifu_rvalid <= 1'b1;
        ifu_rdata  <= data_q[req_idx];
        ifu_rresp  <= 2'b00;
      end else if (fill) begin
        ifu_rvalid <= 1'b1;
        ifu_rdata  <= mem_rdata;
        ifu_rresp  <= mem_rresp;
      end else if (ifu_rready) begin
        ifu_rvalid <= 1'b0;
      end

      if (accept && hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
      if (accept && !hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (accept && !hit) begin
            miss_line   <= ifu_araddr[63:3];
            mem_arvalid <= 1'b1;
            state       <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (fence_i) squash <= 1'b1;
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            state       <= MISS_R;
          end
        end
        MISS_R: begin
          if (fence_i) squash <= 1'b1;
          if (fill) begin
            squash <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_icache.sv
// Directed bench for ifu_icache: cold miss, hit latency, conflict, stall,
// fence during a fill, error fill and reset mid-miss.
module tb_ifu_icache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fence_i = 1'b0;
  logic        ifu_arvalid = 1'b0;
  logic        ifu_arready;
  logic [63:0] ifu_araddr = '0;
  logic        ifu_rvalid;
  logic        ifu_rready = 1'b1;
  logic [1:0]  ifu_rresp;
  logic [63:0] ifu_rdata;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [63:0] mem_araddr;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [1:0]  mem_rresp = 2'b00;
  logic [63:0] mem_rdata = '0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int vectors = 0;
  int errors  = 0;

  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hAAAA_0000_BBBB_0001;
  localparam logic [63:0] DC = 64'hCAFE_F00D_0000_0008;
  localparam logic [63:0] DD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DE = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DX = 64'hBAD0_BAD0_BAD0_BAD0;

  ifu_icache #(.ENTRY_NUM(16)) dut (
    .clk(clk), .rst(rst), .fence_i(fence_i),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp),
    .ifu_rdata(ifu_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full miss transaction; optional fence pulse while waiting for the fill.
  task automatic do_miss(input string tag, input logic [63:0] addr,
                         input logic [63:0] exp_maddr, input logic [63:0] md,
                         input logic [1:0] mr, input bit fence_in_r);
    ifu_rready  = 1'b1;
    ifu_arvalid = 1'b1;
    ifu_araddr  = addr;
    #1 chk({tag, ".arready"}, 64'(ifu_arready), 64'd1);
    tick();
    ifu_arvalid = 1'b0;
    #1;
    chk({tag, ".mem_arvalid"}, 64'(mem_arvalid), 64'd1);
    chk({tag, ".mem_araddr"}, mem_araddr, exp_maddr);
    chk({tag, ".arready_busy"}, 64'(ifu_arready), 64'd0);
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    #1 chk({tag, ".mem_arvalid_drop"}, 64'(mem_arvalid), 64'd0);
    if (fence_in_r) begin
      fence_i = 1'b1;
      tick();
      fence_i = 1'b0;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = md;
    mem_rresp  = mr;
    #1 chk({tag, ".mem_rready"}, 64'(mem_rready), 64'd1);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = DX;
    mem_rresp  = 2'b00;
    #1;
    chk({tag, ".rvalid"}, 64'(ifu_rvalid), 64'd1);
    chk({tag, ".rdata"}, ifu_rdata, md);
    chk({tag, ".rresp"}, 64'(ifu_rresp), 64'(mr));
  endtask

  // Hit: response one cycle after the handshake, no memory traffic.
  task automatic do_hit(input string tag, input logic [63:0] addr, input logic [63:0] exp_data);
    ifu_rready  = 1'b1;
    ifu_arvalid = 1'b1;
    ifu_araddr  = addr;
    #1 chk({tag, ".arready"}, 64'(ifu_arready), 64'd1);
    tick();
    ifu_arvalid = 1'b0;
    #1;
    chk({tag, ".rvalid"}, 64'(ifu_rvalid), 64'd1);
    chk({tag, ".rdata"}, ifu_rdata, exp_data);
    chk({tag, ".rresp"}, 64'(ifu_rresp), 64'd0);
    chk({tag, ".no_mem_ar"}, 64'(mem_arvalid), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst.rvalid", 64'(ifu_rvalid), 64'd0);
    chk("rst.rdata", ifu_rdata, 64'd0);
    chk("rst.rresp", 64'(ifu_rresp), 64'd0);
    chk("rst.mem_arvalid", 64'(mem_arvalid), 64'd0);
    chk("rst.arready", 64'(ifu_arready), 64'd1);
    chk("rst.hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst.miss_cnt", 64'(miss_cnt), 64'd0);

    // 1. Cold miss, offset 4 aligns down
    tick();
    do_miss("cold", 64'h8000_0004, 64'h8000_0000, DA, 2'b00, 1'b0);
    chk("cold.miss_cnt", 64'(miss_cnt), 64'd1);

    // 2. Re-read hits
    tick();
    do_hit("hit0", 64'h8000_0000, DA);
    chk("hit0.hit_cnt", 64'(hit_cnt), 64'd1);

    // 3. Conflict on index 1
    tick();
    do_miss("conf_a", 64'h8000_0008, 64'h8000_0008, DB, 2'b00, 1'b0);
    tick();
    do_miss("conf_b", 64'h8000_0088, 64'h8000_0088, DC, 2'b00, 1'b0);
    tick();
    do_miss("conf_a2", 64'h8000_0008, 64'h8000_0008, DB, 2'b00, 1'b0);
    chk("conf.miss_cnt", 64'(miss_cnt), 64'd4);
    tick();
    do_hit("conf_hit", 64'h8000_000C, DB);
    chk("conf.hit_cnt", 64'(hit_cnt), 64'd2);

    // 4. Stalled hit response, then back-to-back hit
    tick();
    ifu_rready  = 1'b0;
    ifu_arvalid = 1'b1;
    ifu_araddr  = 64'h8000_0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall.rvalid", 64'(ifu_rvalid), 64'd1);
      chk("stall.rdata", ifu_rdata, DA);
      chk("stall.arready", 64'(ifu_arready), 64'd0);
      tick();
    end
    ifu_rready = 1'b1;
    ifu_araddr = 64'h8000_0008;
    #1 chk("b2b.arready", 64'(ifu_arready), 64'd1);
    tick();
    ifu_arvalid = 1'b0;
    #1;
    chk("b2b.rvalid", 64'(ifu_rvalid), 64'd1);
    chk("b2b.rdata", ifu_rdata, DB);
    chk("b2b.hit_cnt", 64'(hit_cnt), 64'd4);

    // 5. Fence during MISS_R: data returned, not allocated
    tick();
    do_miss("fence", 64'h8000_0100, 64'h8000_0100, DD, 2'b00, 1'b1);
    tick();
    do_miss("fence_re", 64'h8000_0100, 64'h8000_0100, DD, 2'b00, 1'b0);
    chk("fence.miss_cnt", 64'(miss_cnt), 64'd6);
    tick();
    do_hit("fence_hit", 64'h8000_0100, DD);

    // 6. Error fill forwarded, line keeps old contents
    tick();
    do_miss("err", 64'h8000_0200, 64'h8000_0200, DE, 2'b10, 1'b0);
    tick();
    do_hit("err_keep", 64'h8000_0100, DD);
    chk("err.hit_cnt", 64'(hit_cnt), 64'd6);
    tick();
    do_miss("err_re", 64'h8000_0200, 64'h8000_0200, DE, 2'b00, 1'b0);
    chk("err.miss_cnt", 64'(miss_cnt), 64'd8);

    // Reset while in MISS_AR
    tick();
    ifu_arvalid = 1'b1;
    ifu_araddr  = 64'h8000_0300;
    tick();
    ifu_arvalid = 1'b0;
    #1 chk("rstmid.pre_arvalid", 64'(mem_arvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.mem_arvalid", 64'(mem_arvalid), 64'd0);
    chk("rstmid.rvalid", 64'(ifu_rvalid), 64'd0);
    chk("rstmid.rdata", ifu_rdata, 64'd0);
    chk("rstmid.arready", 64'(ifu_arready), 64'd1);
    chk("rstmid.mem_rready", 64'(mem_rready), 64'd0);
    chk("rstmid.miss_cnt", 64'(miss_cnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    do_miss("post_rst", 64'h8000_0200, 64'h8000_0200, DE, 2'b00, 1'b0);
    chk("post_rst.miss_cnt", 64'(miss_cnt), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
